sram_req_arbiter: RTL

Arbitrates two sram-like requesters, the CPU instruction-fetch port and the data-access port, onto one shared sram-like memory port. Requests are forwarded combinationally. An in-order tag FIFO records which requester owns each outstanding transaction so that returning `data_ok`/`rdata` is routed to the right requester. The block sits between the CPU top and the single bus bridge.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_req_arbiter_tag_fifo.sv | 62 ++++++
 rtl/sram_req_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the sram request arbiter: requester tags,
// transfer size encodings and the supported outstanding-depth bound.
package sram_arb_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int unsigned MAX_OUTSTANDING_LIMIT = 4;

endpackage

// File: rtl/sram_req_arbiter_tag_fifo.sv
// In-order FIFO of 1-bit requester tags, one entry per transaction that
// has been accepted by memory and is still waiting for its response.
module tag_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         push_tag,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic                         head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] slots;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status flags and guarded push/pop strobes.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = slots[rd_ptr];
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates the instruction and data sram-like requesters onto a single
// memory port and routes in-order responses back via a tag FIFO.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  src_e          grant;
  logic          granted_req;
  logic          lock_vld;
  src_e          lock_src;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_head;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          resp_vld;

  // Grant: a pending (locked) source keeps the port; otherwise data wins.
  always_comb begin
    grant = SRC_INST;
    if (lock_vld && lock_src == SRC_INST && inst_req)      grant = SRC_INST;
    else if (lock_vld && lock_src == SRC_DATA && data_req) grant = SRC_DATA;
    else if (data_req)                                     grant = SRC_DATA;
  end

  // Request forwarding, payload mux and handshake/response routing.
  always_comb begin
    granted_req  = (grant == SRC_DATA) ? data_req : inst_req;
    mem_req      = resetn & granted_req & ~fifo_full;
    inst_addr_ok = mem_addr_ok & mem_req & (grant == SRC_INST);
    data_addr_ok = mem_addr_ok & mem_req & (grant == SRC_DATA);
    push         = mem_req & mem_addr_ok;
    pop          = mem_data_ok & ~fifo_empty;
    resp_vld     = resetn & pop;
    inst_data_ok = resp_vld & (fifo_head == SRC_INST);
    data_data_ok = resp_vld & (fifo_head == SRC_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    if (grant == SRC_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  // Lock tracking: hold the payload source while a request waits for addr_ok.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_vld <= 1'b0;
      lock_src <= SRC_INST;
    end else if (mem_req && !mem_addr_ok) begin
      lock_vld <= 1'b1;
      lock_src <= grant;
    end else if (push) begin
      lock_vld <= 1'b0;
    end else if (lock_vld && !((lock_src == SRC_DATA) ? data_req : inst_req)) begin
      lock_vld <= 1'b0;
    end
  end

  // Sticky flag for responses that arrive with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        proto_err <= 1'b0;
    else if (mem_data_ok && fifo_empty) proto_err <= 1'b1;
  end

  tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (resetn),
    .push     (push),
    .push_tag (grant),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  // Occupancy never exceeds the configured depth.
  count_bound_a: assert property (@(posedge clk) disable iff (!resetn)
    fifo_count <= CW'(MAX_OUTSTANDING));

endmodule
